instr_sequencer: RTL

Fetch/execute sequencer for the lab 4-bit processor. It owns the program counter and instruction register, and steps a 1-cycle-latency instruction ROM. It presents the current opcode to the combinational opcode decoder and consumes the decoder's `clk_dis` (halt) and `jump_en` (branch) outputs to choose the next PC. Execution is controlled by a `run` level and a single-instruction `step` pulse; the block issues one `exec_en` strobe per instruction to the datapath.

---
 rtl/instr_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Fetch/load/execute sequencer for the 4-bit lab processor: owns PC, IR and the
// retired-instruction counter, and steps a 1-cycle-latency instruction ROM.
module instr_sequencer #(
  parameter int PC_W  = 4,
  parameter int IR_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [IR_W-1:0]  rom_data,
  input  logic             clk_dis,
  input  logic             jump_en,
  output logic [PC_W-1:0]  rom_addr,
  output logic [3:0]       opcode,
  output logic [IR_W-1:0]  ir,
  output logic             exec_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        // run wins over step, so a simultaneous step never limits a run to one instruction
        if (run) begin
          state_d = FETCH;
          step_d  = 1'b0;
        end else if (step) begin
          state_d = FETCH;
          step_d  = 1'b1;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_d    = rom_data;
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = sat_inc(cnt_q);
        if (clk_dis) begin
          state_d = HALT;
        end else begin
          if (jump_en) pc_d = ir_q[PC_W-1:0];
          else         pc_d = pc_q + PC_W'(1);
          if (run && !step_q) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
            step_d  = 1'b0;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr  = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[IR_W-1:IR_W-4];
  assign instr_cnt = cnt_q;
  assign exec_en   = (state_q == EXEC);
  assign busy      = (state_q == FETCH) || (state_q == LOAD) || (state_q == EXEC);
  assign halted    = (state_q == HALT);

endmodule
